// File: rtl/accel_controller.sv
// Sequencing controller for the systolic-array accelerator: loads weight rows,
// streams input vectors, waits for the output drain and keeps sticky error flags.
module accel_controller #(
  parameter int ARRAY_DIM  = 8,
  parameter int DATA_W     = 8,
  parameter int MAX_INPUTS = 64,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = $clog2(MAX_INPUTS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  ctrl_reg,
  input  logic                        data_ready,
  input  logic                        out_done,
  input  logic                        output_valid,
  input  logic                        occupancy_err,
  input  logic [ARRAY_DIM*DATA_W-1:0] data,
  input  logic [CNT_W-1:0]            num_inputs,
  output logic [7:0]                  status_reg,
  output logic [15:0]                 error_reg,
  output logic                        get_weights,
  output logic                        get_inputs,
  output logic                        get_out,
  output logic                        in_valid,
  output logic [ARRAY_DIM*DATA_W-1:0] array_inputs,
  output logic [ARRAY_DIM-1:0]        load
);

  localparam int ROW_W  = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ROW_W-1:0]     ROW_LAST  = ROW_W'(ARRAY_DIM - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ARRAY_DIM-1:0] LOAD_ONE  = ARRAY_DIM'(1);
  localparam logic                 TO_EN     = (TIMEOUT != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_WEIGHT, S_WAIT_WEIGHT, S_SEND_WEIGHT,
    S_GET_INPUT, S_WAIT_INPUT, S_SEND_INPUT, S_WAIT_OUT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wl_q, wl_d;
  logic              done_q, done_d;
  logic              get_out_q, get_out_d;
  logic [4:0]        err_q, err_d;

  logic [3:0] cmd_pulse;
  logic [4:0] err_set;
  logic       busy;
  logic       is_wait;
  logic       timeout_hit;
  logic       unused_ctrl;

  assign unused_ctrl = ^ctrl_reg[7:4];
  assign cmd_pulse   = ctrl_reg[3:0] & ~cmd_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign is_wait     = (state_q == S_WAIT_WEIGHT) || (state_q == S_WAIT_INPUT) ||
                       (state_q == S_WAIT_OUT);
  assign timeout_hit = TO_EN && is_wait && (wait_q == WAIT_LAST);

  always_comb begin
    state_d      = state_q;
    cmd_d        = ctrl_reg[3:0];
    row_d        = row_q;
    in_cnt_d     = in_cnt_q;
    count_d      = count_q;
    wl_d         = wl_q;
    done_d       = done_q;
    err_set      = '0;
    get_weights  = 1'b0;
    get_inputs   = 1'b0;
    in_valid     = 1'b0;
    array_inputs = '0;
    load         = '0;
    err_set[0]   = occupancy_err;

    case (state_q)
      S_IDLE: begin
        if (cmd_pulse[1]) begin
          wl_d    = 1'b0;
          done_d  = 1'b0;
          row_d   = '0;
          state_d = S_GET_WEIGHT;
        end else if (cmd_pulse[0]) begin
          if ((num_inputs == '0) || (num_inputs > CNT_W'(MAX_INPUTS))) begin
            err_set[2] = 1'b1;
          end else if (!wl_q) begin
            err_set[3] = 1'b1;
          end else begin
            count_d  = num_inputs;
            in_cnt_d = '0;
            done_d   = 1'b0;
            state_d  = S_GET_INPUT;
          end
        end
      end
      S_GET_WEIGHT: begin
        get_weights = 1'b1;
        state_d     = S_WAIT_WEIGHT;
      end
      S_WAIT_WEIGHT: begin
        if (data_ready) state_d = S_SEND_WEIGHT;
      end
      S_SEND_WEIGHT: begin
        array_inputs = data;
        load         = LOAD_ONE << (ROW_LAST - row_q);
        row_d        = row_q + 1'b1;
        if (row_q == ROW_LAST) begin
          wl_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_GET_WEIGHT;
        end
      end
      S_GET_INPUT: begin
        get_inputs = 1'b1;
        state_d    = S_WAIT_INPUT;
      end
      S_WAIT_INPUT: begin
        if (data_ready) state_d = S_SEND_INPUT;
      end
      S_SEND_INPUT: begin
        in_valid     = 1'b1;
        array_inputs = data;
        in_cnt_d     = in_cnt_q + 1'b1;
        state_d      = (in_cnt_q == count_q - 1'b1) ? S_WAIT_OUT : S_GET_INPUT;
      end
      S_WAIT_OUT: begin
        if (out_done) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A wait state that made no progress this cycle may expire.
    if (timeout_hit && (state_d == state_q)) begin
      err_set[1] = 1'b1;
      state_d    = S_IDLE;
    end

    // Abort overrides whatever the state decided, including a final SEND.
    if (cmd_pulse[2] && busy) begin
      err_set[4] = 1'b1;
      wl_d       = wl_q;
      state_d    = S_IDLE;
    end

    if (state_d == S_IDLE) begin
      row_d    = '0;
      in_cnt_d = '0;
    end

    wait_d    = (is_wait && (state_d == state_q)) ? wait_q + 1'b1 : '0;
    get_out_d = (state_d == S_WAIT_OUT);
    err_d     = (cmd_pulse[3] ? 5'b0 : err_q) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      row_q     <= '0;
      in_cnt_q  <= '0;
      count_q   <= '0;
      wait_q    <= '0;
      wl_q      <= 1'b0;
      done_q    <= 1'b0;
      get_out_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      row_q     <= row_d;
      in_cnt_q  <= in_cnt_d;
      count_q   <= count_d;
      wait_q    <= wait_d;
      wl_q      <= wl_d;
      done_q    <= done_d;
      get_out_q <= get_out_d;
      err_q     <= err_d;
    end
  end

  assign get_out    = get_out_q;
  assign status_reg = {4'b0, |err_q, wl_q, busy, done_q & output_valid};
  assign error_reg  = {11'b0, err_q};

endmodule

// File: doc/accel_controller.md
# accel_controller

Parametrised sequencing controller for the systolic-array accelerator. It sits between the AHB register block, the SRAM buffer and the ARRAY_DIM x ARRAY_DIM systolic array. On software command it fetches weight rows and loads them into the array, then streams a programmable number of input vectors and waits for the outputs to drain. Compared with the fixed 8x8 controller it adds:
- Parametrised array size and data width.
- Weight-valid tracking.
- Command abort.
- Fetch/drain timeout.
- Sticky, software-clearable error reporting.

## Interface
Parameters:
- ARRAY_DIM, 8: rows/columns of the systolic array; number of weight rows per load.
- DATA_W, 8: bits per array element.
- MAX_INPUTS, 64: largest legal input-vector count per inference.
- TIMEOUT, 1024: maximum cycles spent in any wait state; 0 disables the timeout.
- CNT_W, $clog2(MAX_INPUTS+1): width of num_inputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_reg  in  8  command bits: [0] start, [1] load_weights, [2] abort, [3] clear_errors; [7:4] ignored.
- data_ready  in  1  SRAM buffer has `data` valid this cycle.
- out_done  in  1  SRAM buffer has finished collecting outputs.
- output_valid  in  1  output buffer contents are valid.
- occupancy_err  in  1  SRAM buffer occupancy fault.
- data  in  ARRAY_DIM*DATA_W  fetched weight row or input vector.
- num_inputs  in  CNT_W  input vectors for the next inference.
- status_reg  out  8  [0] done, [1] busy, [2] weights_loaded, [3] error_any (OR of error_reg); others 0.
- error_reg  out  16  sticky errors: [0] occupancy, [1] timeout, [2] bad_count, [3] no_weights, [4] aborted; others 0.
- get_weights  out  1  one-cycle weight-row fetch request.
- get_inputs  out  1  one-cycle input-vector fetch request.
- get_out  out  1  registered output-collection request.
- in_valid  out  1  array_inputs carries an input vector.
- array_inputs  out  ARRAY_DIM*DATA_W  data to the array; 0 when unused.
- load  out  ARRAY_DIM  one-hot weight-row load strobe.

## Operation
- Command detection:
  - Each ctrl_reg[3:0] bit is sampled into a register every cycle.
  - cmd_pulse = ctrl_reg[i] & ~sampled[i], acted on in that same cycle.
  - A held level never repeats a command.
- States: IDLE, GET_WEIGHT, WAIT_WEIGHT, SEND_WEIGHT, GET_INPUT, WAIT_INPUT, SEND_INPUT, WAIT_OUT, DONE.
- IDLE:
  - load_weights pulse has priority over start.
  - load_weights: clears weights_loaded, done and the row counter, then goes to GET_WEIGHT.
  - start checks, in this order:
    - num_inputs==0 or num_inputs>MAX_INPUTS: set bad_count, stay in IDLE.
    - else weights_loaded==0: set no_weights, stay in IDLE.
    - else: latch num_inputs, clear the input counter and done, go to GET_INPUT.
  - abort pulse in IDLE is ignored.
- Weight load:
  - GET_WEIGHT asserts get_weights, then goes to WAIT_WEIGHT.
  - WAIT_WEIGHT moves to SEND_WEIGHT on data_ready.
  - SEND_WEIGHT drives array_inputs=data and load = 1<<(ARRAY_DIM-1-row), then increments row.
  - After row ARRAY_DIM-1: set weights_loaded, go to IDLE. Otherwise go to GET_WEIGHT.
- Inference:
  - GET_INPUT, WAIT_INPUT and SEND_INPUT follow the same pattern as weight load.
  - SEND_INPUT drives in_valid=1 and array_inputs=data.
  - After the latched count of vectors, go to WAIT_OUT.
  - WAIT_OUT moves to DONE on out_done.
  - DONE lasts one cycle, sets the done bit, then returns to IDLE.
- done (status_reg[0]):
  - Sticky; it reads 1 only while output_valid is also 1.
  - Cleared by the next accepted start or load_weights.
- busy=1 in every state except IDLE and DONE.
- Abort:
  - An abort pulse in any busy state sends the FSM to IDLE on the next edge and sets aborted.
  - Counters are cleared.
  - If the abort lands during a weight load, weights_loaded stays 0.
- Timeout:
  - A wait counter runs in WAIT_WEIGHT, WAIT_INPUT and WAIT_OUT, and resets on every state change.
  - If it reaches TIMEOUT: set timeout, go to IDLE, clear counters.
- Errors:
  - occupancy_err sets error bit 0 on any cycle.
  - A clear_errors pulse zeroes error_reg.
  - A set event in the same cycle wins over the clear.
- Counter widths:
  - The row counter is $clog2(ARRAY_DIM) bits.
  - The input counter is CNT_W bits and compares against latched_count-1.
  - No wrap is reachable.

## Timing
- Reset value of every output is 0, including status_reg and error_reg. State returns to IDLE and all internal registers clear.
- Reset asserted mid-operation aborts immediately without setting any error bit.
- Command acceptance: the edge at cycle t moves the FSM at the t+1 clock edge.
- get_weights/get_inputs are high exactly one cycle, the cycle after the FSM leaves IDLE or SEND_*.
- data_ready arriving in the same cycle as the fetch request is ignored; it is sampled only in WAIT_*.
- get_out:
  - Registered; rises the cycle after the final SEND_INPUT.
  - Stays high through WAIT_OUT.
  - Drops the cycle after out_done is sampled.
- Per-row weight load latency is 3 cycles with zero-wait SRAM (GET, WAIT with data_ready, SEND). Full load = 3*ARRAY_DIM cycles.
- Inference with zero-wait SRAM: 3*N + out_done wait + 1 (DONE) cycles.
- Simultaneous events:
  - Abort and timeout in the same cycle: both error bits are set.
  - Abort in the same cycle as the final SEND: abort wins; weights_loaded/done are not set.

## Test plan
- Weight load, ARRAY_DIM=8, zero-wait SRAM: load_weights rises -> 8 get_weights pulses and load sequence 0x80,0x40,…,0x01 with matching data; weights_loaded=1 after 24 cycles; busy drops.
- Inference, num_inputs=5: start -> exactly 5 in_valid cycles; get_out high from after the 5th SEND until out_done; with output_valid=1, status_reg=0x05 (done|weights_loaded).
- Illegal starts:
  - start with weights_loaded=0 -> error_reg=0x0008, state stays IDLE, busy never asserts.
  - num_inputs=0 -> error bit 2 set.
  - num_inputs=65 -> error bit 2 set.
- Timeout: TIMEOUT=16, data_ready held 0 -> after 16 WAIT_INPUT cycles, error_reg bit 1 set, busy=0, no further get_inputs.
- Abort on the 4th weight row -> IDLE next cycle, error_reg=0x0010, weights_loaded=0; clear_errors rising -> error_reg=0.
- Reset mid-inference and held ctrl_reg level: rst pulse during SEND_INPUT -> all outputs 0; keeping start=1 after reset generates no new inference.
